xge_mac_reg_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the XGE MAC register block's single access port between `NUM_REQ` requesters, for example a host bus bridge and the MAC statistics updater. It accepts one request at a time and drives a single-cycle read or write strobe into the register block. It then waits for the block's ack and error, and returns one response pulse to the granted requester. Only one transaction is outstanding at a time.

---
 rtl/xge_mac_reg_arb_pkg.sv | 24 ++
 rtl/xge_mac_reg_rr_picker.sv | 36 +++
 rtl/xge_mac_reg_arbiter.sv | 169 ++++++++++++++++
 tb/tb_xge_mac_reg_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xge_mac_reg_arb_pkg.sv
// Shared types and helpers for the XGE MAC register-port arbiter.
//   arb_state_e    : sequencer states (IDLE -> ISSUE -> WAIT -> IDLE)
//   resp_sel_e     : response-register source select
//   tmo_cnt_width  : width of the WAIT-cycle timeout counter
package xge_mac_reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,
    RESP_ACK     = 2'd1,
    RESP_TIMEOUT = 2'd2
  } resp_sel_e;

  // Counter must be able to represent TIMEOUT itself.
  function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/xge_mac_reg_rr_picker.sv
// Combinational round-robin picker.
//   valid       : per-requester pending request
//   ptr         : index of the last granted requester
//   grant_c     : one-hot grant, priority starting at (ptr + 1) mod NUM_REQ
//   grant_idx_c : binary index of grant_c (don't care when no valid)
module xge_mac_reg_rr_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic        found;
  int unsigned k;

  // Walk requesters in rotated order; first valid one wins.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    k           = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr) + 32'd1 + i) % NUM_REQ;
      if (!found && valid[PTR_W'(k)]) begin
        found                 = 1'b1;
        grant_c[PTR_W'(k)]    = 1'b1;
        grant_idx_c           = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/xge_mac_reg_arbiter.sv
// Round-robin arbiter / sequencer sharing the MAC register block port.
// One transaction outstanding: accept (IDLE) -> strobe (ISSUE) -> ack (WAIT),
// response pulse to the grantee on the cycle after the ack.
//   req_*         : NUM_REQ requesters, flattened addr/wdata slices
//   req_ready_o   : combinational one-hot accept
//   resp_*        : registered one-hot response, shared rdata/error
//   regb_*        : register block strobes, address, data, ack/error
// Optional: define XGE_MAC_REG_ARB_TIMEOUT_EN to force an error response
// after TIMEOUT WAIT cycles without ack; otherwise WAIT holds until ack.
module xge_mac_reg_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned REG_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0]                 req_wen_i,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_REQ-1:0]                 resp_valid_o,
  output logic [REG_DATA_WIDTH-1:0]          resp_rdata_o,
  output logic                               resp_error_o,
  output logic [REG_ADDR_WIDTH-1:0]          regb_addr_o,
  output logic [REG_DATA_WIDTH-1:0]          regb_wbdata_o,
  output logic                               regb_wen_o,
  output logic                               regb_ren_o,
  input  logic [REG_DATA_WIDTH-1:0]          regb_rdata_i,
  input  logic                               regb_ack_i,
  input  logic                               error_i
);

  import xge_mac_reg_arb_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("xge_mac_reg_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("xge_mac_reg_arbiter: TIMEOUT must be >= 2");
  end

  arb_state_e                state_q, state_d;
  resp_sel_e                 resp_sel_c;
  logic                      accept_c;
  logic [PTR_W-1:0]          ptr_q;
  logic [NUM_REQ-1:0]        grant_q;
  logic                      wen_q;
  logic [NUM_REQ-1:0]        grant_c;
  logic [PTR_W-1:0]          grant_idx_c;
  logic [REG_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [REG_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // Unflatten requester buses for indexed selection.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata_i[g*REG_DATA_WIDTH +: REG_DATA_WIDTH];
  end

  xge_mac_reg_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid       (req_valid_i),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Accept is only offered in IDLE and never while reset is asserted.
  assign req_ready_o = (state_q == ST_IDLE && !reset) ? grant_c : '0;

`ifdef XGE_MAC_REG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT);
  logic [CNT_W-1:0] tmo_cnt_q;

  // WAIT-cycle counter; cleared while ISSUE so it starts at 0 in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_WAIT && !regb_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, accept and response source.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    resp_sel_c = RESP_NONE;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          accept_c = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (regb_ack_i) begin
          resp_sel_c = RESP_ACK;
          state_d    = ST_IDLE;
        end
`ifdef XGE_MAC_REG_ARB_TIMEOUT_EN
        // Last of TIMEOUT unacknowledged WAIT cycles.
        else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_sel_c = RESP_TIMEOUT;
          state_d    = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction latch, strobes and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= PTR_W'(NUM_REQ - 1);
      grant_q       <= '0;
      wen_q         <= 1'b0;
      regb_addr_o   <= '0;
      regb_wbdata_o <= '0;
      regb_wen_o    <= 1'b0;
      regb_ren_o    <= 1'b0;
      resp_valid_o  <= '0;
      resp_rdata_o  <= '0;
      resp_error_o  <= 1'b0;
    end else begin
      regb_wen_o   <= 1'b0;
      regb_ren_o   <= 1'b0;
      resp_valid_o <= '0;
      if (accept_c) begin
        ptr_q         <= grant_idx_c;
        grant_q       <= grant_c;
        wen_q         <= req_wen_i[grant_idx_c];
        regb_addr_o   <= addr_arr[grant_idx_c];
        regb_wbdata_o <= wdata_arr[grant_idx_c];
        regb_wen_o    <= req_wen_i[grant_idx_c];
        regb_ren_o    <= !req_wen_i[grant_idx_c];
      end
      case (resp_sel_c)
        RESP_ACK: begin
          resp_valid_o <= grant_q;
          resp_error_o <= error_i;
          resp_rdata_o <= (!wen_q && !error_i) ? regb_rdata_i : '0;
        end
        RESP_TIMEOUT: begin
          resp_valid_o <= grant_q;
          resp_error_o <= 1'b1;
          resp_rdata_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_mac_reg_arbiter.sv
`timescale 1ns/1ps
module tb_xge_mac_reg_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_wen, req_ready, resp_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [DW-1:0]         resp_rdata, regb_wbdata, regb_rdata;
  logic                  resp_error;
  logic [AW-1:0]         regb_addr;
  logic                  regb_wen, regb_ren, regb_ack, regb_err;
  logic                  ack_en, ack_force;
  logic [DW-1:0]         regs [3];
  logic [1:0]            exp_g;
  int                    n_cmp = 0;
  int                    n_bad = 0;
  int                    pulses;

  always #5 clk = ~clk;

  xge_mac_reg_arbiter #(
    .NUM_REQ(NUM_REQ), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata), .resp_error_o(resp_error),
    .regb_addr_o(regb_addr), .regb_wbdata_o(regb_wbdata),
    .regb_wen_o(regb_wen), .regb_ren_o(regb_ren),
    .regb_rdata_i(regb_rdata), .regb_ack_i(regb_ack), .error_i(regb_err)
  );

  // Register block: 0x0, 0x4, 0x8 mapped; acks the cycle after a strobe.
  always @(posedge clk) begin
    regb_ack <= ack_force;
    regb_err <= 1'b0;
    if (ack_en && (regb_ren || regb_wen)) begin
      regb_ack <= 1'b1;
      if (regb_addr < 32'hC && regb_addr[1:0] == 2'b00) begin
        if (regb_wen) regs[regb_addr[3:2]] <= regb_wbdata;
        regb_rdata <= regs[regb_addr[3:2]];
      end else begin
        regb_err   <= 1'b1;
        regb_rdata <= 32'hDEAD_BEEF;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[k]           = v;
    req_wen[k]             = w;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
  endtask

  initial begin
    reset = 1'b1; ack_en = 1'b1; ack_force = 1'b0;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    regb_ack = 1'b0; regb_err = 1'b0; regb_rdata = '0;
    regs[0] = 32'h4; regs[1] = 32'h0; regs[2] = 32'h5A5A;

    // Reset state with requests pending: nothing offered.
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h4, 32'h0);
    repeat (2) tick();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_ren", regb_ren, 0);
    check_eq("rst_wen", regb_wen, 0);
    check_eq("rst_addr", regb_addr, 0);
    check_eq("rst_rdata", resp_rdata, 0);
    check_eq("rst_error", resp_error, 0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // Single read of 0x0 by req0.
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
    check_eq("rd_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    check_eq("rd_ren", regb_ren, 1);
    check_eq("rd_wen", regb_wen, 0);
    check_eq("rd_addr", regb_addr, 0);
    check_eq("rd_ready_busy", req_ready, 0);
    tick();
    check_eq("rd_ren_drop", regb_ren, 0);
    check_eq("rd_no_early_resp", resp_valid, 0);
    tick();
    check_eq("rd_resp_valid", resp_valid, 2'b01);
    check_eq("rd_rdata", resp_rdata, 32'h4);
    check_eq("rd_error", resp_error, 0);

    // Reset, then stray ack in IDLE must be ignored.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    ack_force = 1'b1; tick(); ack_force = 1'b0; tick();
    check_eq("stray_ack", resp_valid, 0);

    // Simultaneous writes to 0x4: req0 first, req1 at T+3.
    set_req(0, 1'b1, 1'b1, 32'h4, 32'hA);
    set_req(1, 1'b1, 1'b1, 32'h4, 32'hB); #1;
    check_eq("wr_ready0", req_ready, 2'b01);
    tick(); req_valid[0] = 1'b0;
    check_eq("wr_wen0", regb_wen, 1);
    check_eq("wr_data0", regb_wbdata, 32'hA);
    tick(); tick();
    check_eq("wr_resp0", resp_valid, 2'b01);
    check_eq("wr_rdata0", resp_rdata, 0);
    check_eq("wr_error0", resp_error, 0);
    check_eq("wr_ready1", req_ready, 2'b10);
    tick(); req_valid[1] = 1'b0;
    check_eq("wr_wen1", regb_wen, 1);
    check_eq("wr_data1", regb_wbdata, 32'hB);
    tick(); tick();
    check_eq("wr_resp1", resp_valid, 2'b10);
    set_req(0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
    check_eq("rb_ready", req_ready, 2'b01);
    tick(); req_valid = '0; tick(); tick();
    check_eq("rb_resp", resp_valid, 2'b01);
    check_eq("rb_rdata", resp_rdata, 32'hB);

    // Unmapped read, then a normal read.
    set_req(1, 1'b1, 1'b0, 32'hC, 32'h0); #1;
    check_eq("um_ready", req_ready, 2'b10);
    tick(); req_valid = '0; tick(); tick();
    check_eq("um_resp", resp_valid, 2'b10);
    check_eq("um_error", resp_error, 1);
    check_eq("um_rdata", resp_rdata, 0);
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0); #1;
    check_eq("um_next_ready", req_ready, 2'b01);
    tick(); req_valid = '0; tick(); tick();
    check_eq("um_next_resp", resp_valid, 2'b01);
    check_eq("um_next_rdata", resp_rdata, 32'h5A5A);
    check_eq("um_next_error", resp_error, 0);

    // No ack from the register block.
    ack_en = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0); #1;
    check_eq("to_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
`ifdef XGE_MAC_REG_ARB_TIMEOUT_EN
    repeat (16) tick();
    check_eq("to_not_yet", resp_valid, 0);
    tick();
    check_eq("to_resp", resp_valid, 2'b01);
    check_eq("to_error", resp_error, 1);
    check_eq("to_rdata", resp_rdata, 0);
    // Start another transaction and leave it hanging in WAIT.
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0); #1;
    check_eq("rw_ready", req_ready, 2'b10);
    tick(); req_valid = '0;
    check_eq("rw_ren", regb_ren, 1);
    tick();
`else
    pulses = 0;
    repeat (30) begin
      tick();
      if (resp_valid != 0) pulses++;
    end
    check_eq("to_no_resp", pulses, 0);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0); #1;
    check_eq("to_stuck_ready", req_ready, 0);
`endif

    // Reset while in WAIT.
    reset = 1'b1; #1;
    check_eq("rw_resp_valid", resp_valid, 0);
    check_eq("rw_ren_off", regb_ren, 0);
    check_eq("rw_wen_off", regb_wen, 0);
    check_eq("rw_ready_off", req_ready, 0);
    check_eq("rw_addr_off", regb_addr, 0);
    check_eq("rw_error_off", resp_error, 0);
    check_eq("rw_rdata_off", resp_rdata, 0);
    req_valid = '0; ack_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check_eq("rw_no_resp", resp_valid, 0);

    // Continuous load: grants alternate starting with req0.
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    exp_g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("cl_ready", req_ready, exp_g);
      tick(); tick(); tick();
      check_eq("cl_resp", resp_valid, exp_g);
      check_eq("cl_rdata", resp_rdata, (exp_g == 2'b01) ? 32'h4 : 32'h5A5A);
      exp_g = ~exp_g;
    end
    // Withdraw before accept: no transaction follows.
    req_valid = '0; #1;
    check_eq("wd_ready", req_ready, 0);
    tick();
    check_eq("wd_ren", regb_ren, 0);
    tick(); tick();
    check_eq("wd_resp", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
